// File: rtl/hc4e_data_ram.sv
// HC4e data-memory responder: 16-nibble RAM plus one memory-mapped I/O port.
// CPU strobes, address and data are synchronised into clk; a small FSM owns the data_bus drive.
module hc4e_data_ram #(
   parameter int unsigned       ADDR_W      = 4,
   parameter int unsigned       DATA_W      = 4,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter bit                IO_ENABLE   = 1'b1,
   parameter logic [ADDR_W-1:0] IO_ADDR     = ADDR_W'(4'hF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address_bus,
   inout  wire  [DATA_W-1:0] data_bus,
   input  logic              nRAM_RD,
   input  logic              nRAM_WR,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic              busy,
   output logic              bus_error
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   logic [SYNC_STAGES-1:0] rd_sync;
   logic [SYNC_STAGES-1:0] wr_sync;
   logic [ADDR_W-1:0]      addr_sync [SYNC_STAGES];
   logic [DATA_W-1:0]      data_sync [SYNC_STAGES];
   logic [DATA_W-1:0]      in_sync   [SYNC_STAGES];

   logic              rd_s;
   logic              wr_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] data_s;
   logic [DATA_W-1:0] in_s;

   state_t            state;
   logic              data_oe;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic [DATA_W-1:0] mem [DEPTH];

   logic addr_is_io;
   logic w_is_io;

   // Strobes and bus share one pipeline depth so they stay time-aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_sync <= '1;
         wr_sync <= '1;
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            addr_sync[i] <= '0;
            data_sync[i] <= '0;
            in_sync[i]   <= '0;
         end
      end else begin
         rd_sync[0]   <= nRAM_RD;
         wr_sync[0]   <= nRAM_WR;
         addr_sync[0] <= address_bus;
         data_sync[0] <= data_bus;
         in_sync[0]   <= in_port;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            rd_sync[i]   <= rd_sync[i-1];
            wr_sync[i]   <= wr_sync[i-1];
            addr_sync[i] <= addr_sync[i-1];
            data_sync[i] <= data_sync[i-1];
            in_sync[i]   <= in_sync[i-1];
         end
      end
   end

   assign rd_s   = rd_sync[SYNC_STAGES-1];
   assign wr_s   = wr_sync[SYNC_STAGES-1];
   assign addr_s = addr_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];
   assign in_s   = in_sync[SYNC_STAGES-1];

   assign addr_is_io = IO_ENABLE && (addr_s == IO_ADDR);
   assign w_is_io    = IO_ENABLE && (w_addr == IO_ADDR);

   // Bus FSM; a write commits only once the strobe has been seen released.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         data_oe   <= 1'b0;
         busy      <= 1'b0;
         bus_error <= 1'b0;
         rd_data   <= '0;
         w_addr    <= '0;
         w_data    <= '0;
         out_port  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (!rd_s && !wr_s) begin
                  bus_error <= 1'b1;
               end else if (!rd_s) begin
                  state   <= READ;
                  busy    <= 1'b1;
                  data_oe <= 1'b1;
                  rd_data <= addr_is_io ? in_s : mem[addr_s];
               end else if (!wr_s) begin
                  state  <= WRITE;
                  busy   <= 1'b1;
                  w_addr <= addr_s;
                  w_data <= data_s;
               end
            end
            READ: begin
               if (!wr_s) begin
                  bus_error <= 1'b1;
               end
               if (rd_s) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  data_oe <= 1'b0;
               end
            end
            WRITE: begin
               if (!rd_s) begin
                  bus_error <= 1'b1;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end else if (wr_s) begin
                  if (w_is_io) begin
                     out_port <= w_data;
                  end else begin
                     mem[w_addr] <= w_data;
                  end
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  w_addr <= addr_s;
                  w_data <= data_s;
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               data_oe <= 1'b0;
            end
         endcase
      end
   end

   assign data_bus = data_oe ? rd_data : 'z;

endmodule

// File: tb/tb_hc4e_data_ram.sv
// Bench for hc4e_data_ram: one instance with the I/O port mapped, one as plain RAM, sharing CPU traffic.
module tb_hc4e_data_ram;

   typedef struct {
      logic [3:0] data;
      int         cycles;
      int         start;
   } rd_exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] address;
   logic       nRAM_RD;
   logic       nRAM_WR;
   logic [3:0] in_port;
   logic [3:0] cpu_data;
   logic       cpu_oe;
   logic [3:0] out_io, out_ram;
   logic       busy_io, busy_ram;
   logic       err_io, err_ram;
   wire  [3:0] bus_io;
   wire  [3:0] bus_ram;

   int      vectors     = 0;
   int      miscompares = 0;
   int      cyc         = 0;
   bit      mon_en      = 1'b0;
   rd_exp_t q_io[$];
   rd_exp_t q_ram[$];
   string   tag[2] = '{"io", "ram"};

   assign bus_io  = cpu_oe ? cpu_data : 4'bz;
   assign bus_ram = cpu_oe ? cpu_data : 4'bz;

   hc4e_data_ram #(.IO_ENABLE(1'b1)) dut_io (
      .clk(clk), .reset(reset), .address_bus(address), .data_bus(bus_io),
      .nRAM_RD(nRAM_RD), .nRAM_WR(nRAM_WR), .in_port(in_port),
      .out_port(out_io), .busy(busy_io), .bus_error(err_io)
   );

   hc4e_data_ram #(.IO_ENABLE(1'b0)) dut_ram (
      .clk(clk), .reset(reset), .address_bus(address), .data_bus(bus_ram),
      .nRAM_RD(nRAM_RD), .nRAM_WR(nRAM_WR), .in_port(in_port),
      .out_port(out_ram), .busy(busy_ram), .bus_error(err_ram)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_read(input logic [3:0] e_io, input logic [3:0] e_ram, input int cycles);
      rd_exp_t e;
      e.cycles = cycles;
      e.start  = cyc + 1;
      e.data   = e_io;
      q_io.push_back(e);
      e.data   = e_ram;
      q_ram.push_back(e);
   endtask

   // 10-clk read strobe; expected data per instance goes to the scoreboard.
   task automatic do_read(input logic [3:0] a, input logic [3:0] e_io, input logic [3:0] e_ram);
      @(negedge clk);
      address = a;
      nRAM_RD = 1'b0;
      push_read(e_io, e_ram, 10);
      repeat (5) @(negedge clk);
      check("busy_io mid-read", busy_io, 1);
      check("busy_ram mid-read", busy_ram, 1);
      repeat (5) @(negedge clk);
      nRAM_RD = 1'b1;
      idle(5);
   endtask

   // 10-clk write strobe; m is the first edge that samples the strobe high.
   task automatic do_write(input logic [3:0] a, input logic [3:0] d, output int m);
      @(negedge clk);
      address  = a;
      cpu_data = d;
      cpu_oe   = 1'b1;
      nRAM_WR  = 1'b0;
      repeat (5) @(negedge clk);
      check("busy_io mid-write", busy_io, 1);
      check("busy_ram mid-write", busy_ram, 1);
      repeat (5) @(negedge clk);
      nRAM_WR = 1'b0 | 1'b1;
      cpu_oe  = 1'b0;
      m = cyc + 1;
   endtask

   // Scoreboard monitor: a rising drive enable pops one expected read.
   initial begin : monitor
      bit         prev[2];
      bit         live[2];
      int         cnt[2];
      rd_exp_t    cur[2];
      bit         oe_now;
      logic [3:0] val;
      for (int i = 0; i < 2; i++) begin
         prev[i] = 1'b0;
         live[i] = 1'b0;
         cnt[i]  = 0;
      end
      wait (mon_en);
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            oe_now = (i == 0) ? dut_io.data_oe : dut_ram.data_oe;
            val    = (i == 0) ? bus_io : bus_ram;
            if (oe_now && !prev[i]) begin
               cnt[i] = 1;
               if ((i == 0 ? q_io.size() : q_ram.size()) == 0) begin
                  check($sformatf("%s unexpected drive", tag[i]), 1, 0);
                  live[i] = 1'b0;
               end else begin
                  cur[i]  = (i == 0) ? q_io.pop_front() : q_ram.pop_front();
                  live[i] = 1'b1;
                  check($sformatf("%s drive start edge", tag[i]), cyc, cur[i].start + 2);
                  check($sformatf("%s read data", tag[i]), val, cur[i].data);
               end
            end else if (oe_now) begin
               cnt[i]++;
            end else if (prev[i] && live[i]) begin
               check($sformatf("%s drive length", tag[i]), cnt[i], cur[i].cycles);
               live[i] = 1'b0;
            end
            prev[i] = oe_now;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: run did not finish, got cycle %0d, expected < 20000", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int m;
      reset    = 1'b1;
      nRAM_RD  = 1'b1;
      nRAM_WR  = 1'b1;
      address  = '0;
      in_port  = '0;
      cpu_data = '0;
      cpu_oe   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      check("reset out_io", out_io, 0);
      check("reset out_ram", out_ram, 0);
      check("reset busy_io", busy_io, 0);
      check("reset err_io", err_io, 0);
      check("reset err_ram", err_ram, 0);
      check("reset oe_io", dut_io.data_oe, 0);
      check("reset oe_ram", dut_ram.data_oe, 0);
      mon_en = 1'b1;

      // Cleared memory everywhere; I/O port reads in_port=0.
      for (int a = 0; a < 16; a++) do_read(4'(a), 4'h0, 4'h0);
      check("after reads err_io", err_io, 0);

      do_write(4'h3, 4'hA, m);
      idle(5);
      do_read(4'h3, 4'hA, 4'hA);

      // I/O port write visible at edge m+2, not before.
      in_port = 4'h9;
      do_write(4'hF, 4'h5, m);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("out_io before m+2", out_io, 0);
      @(posedge clk); #1;
      check("out_io at m+2", out_io, 5);
      check("out_ram plain", out_ram, 0);
      idle(5);
      do_read(4'hF, 4'h9, 4'h5);
      check("out_io after io read", out_io, 5);

      // Both strobes low: protocol error, no write, no drive.
      @(negedge clk);
      address  = 4'h5;
      cpu_data = 4'h7;
      cpu_oe   = 1'b1;
      nRAM_RD  = 1'b0;
      nRAM_WR  = 1'b0;
      repeat (4) @(negedge clk);
      check("both-low err_io", err_io, 1);
      check("both-low err_ram", err_ram, 1);
      check("both-low oe_io", dut_io.data_oe, 0);
      check("both-low oe_ram", dut_ram.data_oe, 0);
      repeat (6) @(negedge clk);
      nRAM_RD = 1'b1;
      nRAM_WR = 1'b1;
      cpu_oe  = 1'b0;
      idle(5);
      check("sticky err_io", err_io, 1);
      do_read(4'h5, 4'h0, 4'h0);
      check("sticky err_ram", err_ram, 1);

      // Reset in the middle of a read of a written address.
      do_write(4'h6, 4'hC, m);
      idle(5);
      @(negedge clk);
      address = 4'h6;
      nRAM_RD = 1'b0;
      push_read(4'hC, 4'hC, 3);
      repeat (5) @(negedge clk);
      reset   = 1'b1;
      nRAM_RD = 1'b1;
      @(posedge clk); #1;
      check("reset-edge oe_io", dut_io.data_oe, 0);
      check("reset-edge oe_ram", dut_ram.data_oe, 0);
      check("reset-edge busy_io", busy_io, 0);
      check("reset-edge busy_ram", busy_ram, 0);
      @(negedge clk);
      reset = 1'b0;
      check("post-reset err_io", err_io, 0);
      check("post-reset out_io", out_io, 0);
      idle(4);
      do_read(4'h6, 4'h0, 4'h0);

      // Fill every address with 15-addr, then read them all back.
      for (int a = 0; a < 16; a++) begin
         do_write(4'(a), 4'(15 - a), m);
         idle(4);
      end
      for (int a = 0; a < 16; a++) begin
         do_read(4'(a), (a == 15) ? 4'h9 : 4'(15 - a), 4'(15 - a));
      end
      check("final out_ram", out_ram, 0);
      check("final out_io", out_io, 0);
      check("final err_io", err_io, 0);
      check("final err_ram", err_ram, 0);
      check("scoreboard drained", q_io.size() + q_ram.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
